ace_snoop_arbiter: RTL and testbench
====================================

// Module: ace_snoop_arbiter
// PURPOSE
// - Shares one ACE snoop-address (AC) channel among NumReq snoop sources.
// - Uses round-robin arbitration and a registered AC output stage.
// - Routes each in-order snoop response (CR) back to the source that issued the
//   matching AC, using an ID-tracking FIFO.
// - Sits between the interconnect's snoop generators and the snooped master port.
// PARAMETERS
// - NumReq          4   number of snoop sources (>=2)
// - AddrWidth       64  AC address width
// - MaxOutstanding  8   AC beats issued with CR pending (>=1); sets the tracking FIFO depth
// PORTS
// - clk_i           in   1                    clock, rising edge
// - rst_ni          in   1                    asynchronous reset, active-low
// - req_ac_valid_i  in   NumReq               per-source AC valid
// - req_ac_ready_o  out  NumReq               per-source AC ready (one-hot or zero)
// - req_ac_addr_i   in   NumReq*AddrWidth     per-source acaddr, packed, source 0 at LSBs
// - req_ac_snoop_i  in   NumReq*4             per-source acsnoop (ace_pkg::arsnoop_t), packed
// - req_ac_prot_i   in   NumReq*3             per-source acprot, packed
// - req_cr_valid_o  out  NumReq               per-source CR valid (one-hot or zero)
// - req_cr_ready_i  in   NumReq               per-source CR ready
// - req_cr_resp_o   out  5                    crresp, broadcast; qualified by req_cr_valid_o
// - mst_ac_valid_o  out  1                    AC valid to the snooped master
// - mst_ac_ready_i  in   1                    AC ready from the snooped master
// - mst_ac_addr_o   out  AddrWidth            acaddr
// - mst_ac_snoop_o  out  4                    acsnoop
// - mst_ac_prot_o   out  3                    acprot
// - mst_cr_valid_i  in   1                    CR valid from the snooped master
// - mst_cr_ready_o  out  1                    CR ready to the snooped master
// - mst_cr_resp_i   in   5                    crresp from the snooped master
// - busy_o          out  1                    AC stage full or any CR outstanding
// BEHAVIOUR
// - Reset values: all valid/ready outputs 0; busy_o 0; AC stage empty with payload 0;
//   RR pointer 0; FIFO empty; outstanding count 0. Reset asserted mid-transfer drops all state.
// - AC stage: one register (valid + payload + source id).
//   - Loads when it is empty, or when it drains in the same cycle (mst_ac_valid_o && mst_ac_ready_i).
//   - Loading also requires the outstanding count, including the load, to be <= MaxOutstanding.
// - Arbitration, computed only when a load is allowed:
//   - Grant the first valid source at or after the RR pointer, wrapping modulo NumReq.
//   - req_ac_ready_o[g] = 1 for the granted source only; the handshake loads the stage.
//   - After each grant the RR pointer moves to g+1, wrapping to 0 after NumReq-1.
//   - No valid source: no grant, pointer unchanged.
// - AC latency: 1 cycle from source handshake to mst_ac_valid_o. Full throughput of 1 beat/cycle.
// - AXI stability: mst_ac_valid_o and the payload hold until mst_ac_ready_i; never retracted.
// - Tracking FIFO, depth MaxOutstanding:
//   - Push the source id on each mst AC handshake.
//   - Pop on each mst CR handshake. CR is in order with AC.
// - Outstanding count = AC stage occupancy + FIFO entries, range 0..MaxOutstanding.
//   - At MaxOutstanding, no new load.
//   - A CR pop in the same cycle does NOT free the slot until the next cycle. This keeps
//     the timing deterministic and the FIFO never overflows.
// - CR routing, combinational:
//   - req_cr_valid_o[head] = mst_cr_valid_i && !fifo_empty.
//   - mst_cr_ready_o = req_cr_ready_i[head] && !fifo_empty.
//   - req_cr_resp_o = mst_cr_resp_i.
// - CR with the FIFO empty is a protocol error:
//   - mst_cr_ready_o stays 0.
//   - Simulation-only assertion fires.
// - Simultaneous AC push and CR pop: FIFO count unchanged, head advances.
// - busy_o = stage valid || !fifo_empty.
// CONFIGURATION
// - ACE_SNOOP_ARB_FIXED_PRIO_EN defined:
//   - Fixed priority; lowest-index valid source wins.
//   - RR pointer removed.
// - Undefined (default): round-robin as above.
// - Both modes keep the stage, FIFO and CR routing identical.
// TESTING
// - Reset; all req_ac_valid_i=4'b1111, mst_ac_ready_i=1 -> grants 0,1,2,3,0 on consecutive
//   cycles; mst_ac_valid_o first rises 1 cycle after the first grant.
// - Source 2 issues acsnoop=4'b0111, addr=0x1000; mst_ac_ready_i held 0 for 5 cycles ->
//   payload stable all 5 cycles; req_ac_ready_o=0 while the stage is full and not draining.
// - Issue 8 ACs with no CR (MaxOutstanding=8) -> 9th source blocked.
//   - One CR handshake frees the slot.
//   - Next grant comes 1 cycle after the CR handshake, not in the same cycle.
// - AC order src1,src3,src0; CR resps 5'h01,5'h02,5'h03 -> delivered to src1,src3,src0
//   respectively; req_cr_ready_i[3]=0 stalls mst_cr_ready_o.
// - Assert rst_ni low with 3 CRs outstanding and the stage full -> all outputs 0
//   immediately; after release the next AC grant is to the lowest valid source from pointer 0.
// - With ACE_SNOOP_ARB_FIXED_PRIO_EN, sources 0 and 3 continuously valid -> source 0 always
//   granted; source 3 never granted.

Source files
------------

// File: rtl/ace_snoop_arbiter.sv
// ACE snoop-address (AC) arbiter with registered AC stage and in-order CR return routing.
// Define ACE_SNOOP_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module ace_snoop_arbiter #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_ac_valid_i,
  output logic [NumReq-1:0]             req_ac_ready_o,
  input  logic [NumReq*AddrWidth-1:0]   req_ac_addr_i,
  input  logic [NumReq*4-1:0]           req_ac_snoop_i,
  input  logic [NumReq*3-1:0]           req_ac_prot_i,
  output logic [NumReq-1:0]             req_cr_valid_o,
  input  logic [NumReq-1:0]             req_cr_ready_i,
  output logic [4:0]                    req_cr_resp_o,
  output logic                          mst_ac_valid_o,
  input  logic                          mst_ac_ready_i,
  output logic [AddrWidth-1:0]          mst_ac_addr_o,
  output logic [3:0]                    mst_ac_snoop_o,
  output logic [2:0]                    mst_ac_prot_o,
  input  logic                          mst_cr_valid_i,
  output logic                          mst_cr_ready_o,
  input  logic [4:0]                    mst_cr_resp_i,
  output logic                          busy_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW:0] OccMax = (CntW+1)'(MaxOutstanding);

  logic                 stage_valid;
  logic [AddrWidth-1:0] stage_addr;
  logic [3:0]           stage_snoop;
  logic [2:0]           stage_prot;
  logic [IdxW-1:0]      stage_src;

  logic [IdxW-1:0]      fifo_mem [MaxOutstanding];
  logic [PtrW-1:0]      fifo_wr_ptr;
  logic [PtrW-1:0]      fifo_rd_ptr;
  logic [CntW-1:0]      fifo_cnt;
  logic                 fifo_empty;
  logic [IdxW-1:0]      head_src;

  logic [CntW:0]        occ;
  logic                 load_ok;
  logic                 grant_found;
  logic [IdxW-1:0]      grant_idx;
  logic                 ac_take;
  logic                 ac_hs;
  logic                 cr_pop;

  assign ac_hs      = stage_valid && mst_ac_ready_i;
  assign fifo_empty = (fifo_cnt == '0);
  assign occ        = {1'b0, fifo_cnt} + (CntW+1)'(stage_valid);

  // A CR pop this cycle is deliberately not counted: the slot frees one cycle later.
  assign load_ok = rst_ni && (!stage_valid || ac_hs) && (occ < OccMax);

`ifdef ACE_SNOOP_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!grant_found && req_ac_valid_i[i]) begin
        grant_found = 1'b1;
        grant_idx   = IdxW'(i);
      end
    end
  end
`else
  logic [IdxW-1:0] rr_ptr;
  int unsigned     rr_cand;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_cand     = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      rr_cand = (32'(rr_ptr) + i) % NumReq;
      if (!grant_found && req_ac_valid_i[rr_cand]) begin
        grant_found = 1'b1;
        grant_idx   = IdxW'(rr_cand);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
    end else if (ac_take) begin
      rr_ptr <= (32'(grant_idx) == NumReq - 1) ? '0 : grant_idx + 1'b1;
    end
  end
`endif

  always_comb begin
    req_ac_ready_o = '0;
    if (load_ok && grant_found) begin
      req_ac_ready_o[grant_idx] = 1'b1;
    end
  end

  assign ac_take = |(req_ac_valid_i & req_ac_ready_o);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_valid <= 1'b0;
      stage_addr  <= '0;
      stage_snoop <= '0;
      stage_prot  <= '0;
      stage_src   <= '0;
    end else if (ac_take) begin
      stage_valid <= 1'b1;
      stage_addr  <= req_ac_addr_i[grant_idx*AddrWidth +: AddrWidth];
      stage_snoop <= req_ac_snoop_i[grant_idx*4 +: 4];
      stage_prot  <= req_ac_prot_i[grant_idx*3 +: 3];
      stage_src   <= grant_idx;
    end else if (ac_hs) begin
      stage_valid <= 1'b0;
    end
  end

  assign mst_ac_valid_o = stage_valid;
  assign mst_ac_addr_o  = stage_addr;
  assign mst_ac_snoop_o = stage_snoop;
  assign mst_ac_prot_o  = stage_prot;

  assign head_src = fifo_mem[fifo_rd_ptr];
  assign cr_pop   = mst_cr_valid_i && mst_cr_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_wr_ptr <= '0;
      fifo_rd_ptr <= '0;
      fifo_cnt    <= '0;
      for (int unsigned i = 0; i < MaxOutstanding; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (ac_hs) begin
        fifo_mem[fifo_wr_ptr] <= stage_src;
        fifo_wr_ptr <= (32'(fifo_wr_ptr) == MaxOutstanding - 1) ? '0 : fifo_wr_ptr + 1'b1;
      end
      if (cr_pop) begin
        fifo_rd_ptr <= (32'(fifo_rd_ptr) == MaxOutstanding - 1) ? '0 : fifo_rd_ptr + 1'b1;
      end
      if (ac_hs && !cr_pop) begin
        fifo_cnt <= fifo_cnt + 1'b1;
      end else if (!ac_hs && cr_pop) begin
        fifo_cnt <= fifo_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    req_cr_valid_o = '0;
    if (mst_cr_valid_i && !fifo_empty) begin
      req_cr_valid_o[head_src] = 1'b1;
    end
  end

  assign mst_cr_ready_o = req_cr_ready_i[head_src] && !fifo_empty;
  assign req_cr_resp_o  = mst_cr_resp_i;
  assign busy_o         = stage_valid || !fifo_empty;

`ifndef SYNTHESIS
  cr_without_ac: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mst_cr_valid_i |-> !fifo_empty);

  ac_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mst_ac_valid_o && !mst_ac_ready_i) |=>
      (mst_ac_valid_o && $stable(mst_ac_addr_o) && $stable(mst_ac_snoop_o)
       && $stable(mst_ac_prot_o)));
`endif

endmodule

// File: tb/tb_ace_snoop_arbiter.sv
// Self-checking bench for ace_snoop_arbiter: vector table plus AC payload / CR routing scoreboards.
module tb_ace_snoop_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 64;
  localparam int unsigned MO = 8;
`ifdef ACE_SNOOP_ARB_FIXED_PRIO_EN
  localparam bit FixedPrio = 1'b1;
`else
  localparam bit FixedPrio = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [N-1:0]    req_ac_valid_i;
  logic [N-1:0]    req_ac_ready_o;
  logic [N*AW-1:0] req_ac_addr_i;
  logic [N*4-1:0]  req_ac_snoop_i;
  logic [N*3-1:0]  req_ac_prot_i;
  logic [N-1:0]    req_cr_valid_o;
  logic [N-1:0]    req_cr_ready_i;
  logic [4:0]      req_cr_resp_o;
  logic            mst_ac_valid_o;
  logic            mst_ac_ready_i;
  logic [AW-1:0]   mst_ac_addr_o;
  logic [3:0]      mst_ac_snoop_o;
  logic [2:0]      mst_ac_prot_o;
  logic            mst_cr_valid_i;
  logic            mst_cr_ready_o;
  logic [4:0]      mst_cr_resp_i;
  logic            busy_o;

  ace_snoop_arbiter #(
    .NumReq(N),
    .AddrWidth(AW),
    .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .req_ac_valid_i(req_ac_valid_i),
    .req_ac_ready_o(req_ac_ready_o),
    .req_ac_addr_i(req_ac_addr_i),
    .req_ac_snoop_i(req_ac_snoop_i),
    .req_ac_prot_i(req_ac_prot_i),
    .req_cr_valid_o(req_cr_valid_o),
    .req_cr_ready_i(req_cr_ready_i),
    .req_cr_resp_o(req_cr_resp_o),
    .mst_ac_valid_o(mst_ac_valid_o),
    .mst_ac_ready_i(mst_ac_ready_i),
    .mst_ac_addr_o(mst_ac_addr_o),
    .mst_ac_snoop_o(mst_ac_snoop_o),
    .mst_ac_prot_o(mst_ac_prot_o),
    .mst_cr_valid_i(mst_cr_valid_i),
    .mst_cr_ready_o(mst_cr_ready_o),
    .mst_cr_resp_i(mst_cr_resp_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] valid;
    logic       mrdy;
    logic [3:0] exp_rdy;
    logic       exp_mvalid;
    logic       exp_busy;
  } vec_t;

  typedef struct {
    logic [63:0] addr;
    logic [3:0]  snoop;
    logic [2:0]  prot;
    int unsigned src;
  } ac_t;

  vec_t        tbl[10];
  ac_t         ac_q[$];
  int unsigned cr_q[$];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int unsigned s);
    return 4'b0001 << s;
  endfunction

  function automatic int unsigned oh_idx(input logic [3:0] v);
    int unsigned r = 0;
    for (int unsigned i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic ac_t pay(input int unsigned s, input int unsigned r);
    ac_t p;
    p.addr  = {16'(s + 1), 16'hBEEF, 32'(r)};
    p.snoop = 4'(s + r);
    p.prot  = 3'(s * 2 + r);
    p.src   = s;
    return p;
  endfunction

  task automatic drive_payloads(input int unsigned r);
    ac_t p;
    for (int unsigned s = 0; s < N; s++) begin
      p = pay(s, r);
      req_ac_addr_i[s*AW +: AW] = p.addr;
      req_ac_snoop_i[s*4 +: 4]  = p.snoop;
      req_ac_prot_i[s*3 +: 3]   = p.prot;
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni         = 1'b0;
    req_ac_valid_i = '0;
    req_ac_addr_i  = '0;
    req_ac_snoop_i = '0;
    req_ac_prot_i  = '0;
    req_cr_ready_i = '0;
    mst_ac_ready_i = 1'b0;
    mst_cr_valid_i = 1'b0;
    mst_cr_resp_i  = '0;
    ac_q.delete();
    cr_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ac_t         e;
    logic [3:0]  cr_rdy_tbl[4];
    logic [4:0]  cr_resp_tbl[4];
    logic [3:0]  exp_v;
    logic        exp_r;

    for (int unsigned r = 0; r < 8; r++) begin
      tbl[r].valid      = 4'b1111;
      tbl[r].mrdy       = 1'b1;
      tbl[r].exp_rdy    = FixedPrio ? 4'b0001 : oh(r % N);
      tbl[r].exp_mvalid = (r != 0);
      tbl[r].exp_busy   = (r != 0);
    end
    tbl[8] = '{valid: 4'b1111, mrdy: 1'b1, exp_rdy: 4'b0000, exp_mvalid: 1'b1, exp_busy: 1'b1};
    tbl[9] = '{valid: 4'b1111, mrdy: 1'b1, exp_rdy: 4'b0000, exp_mvalid: 1'b0, exp_busy: 1'b1};

    // Reset state
    do_reset();
    #4;
    check("rst ac_ready", 64'(req_ac_ready_o), 64'h0);
    check("rst mst_valid", 64'(mst_ac_valid_o), 64'h0);
    check("rst mst_addr", 64'(mst_ac_addr_o), 64'h0);
    check("rst cr_valid", 64'(req_cr_valid_o), 64'h0);
    check("rst cr_ready", 64'(mst_cr_ready_o), 64'h0);
    check("rst busy", 64'(busy_o), 64'h0);
    tick();

    // Grant rotation, 1-cycle latency, and the outstanding limit
    for (int unsigned r = 0; r < 10; r++) begin
      req_ac_valid_i = tbl[r].valid;
      mst_ac_ready_i = tbl[r].mrdy;
      drive_payloads(r);
      #4;
      check($sformatf("t1 ready r%0d", r), 64'(req_ac_ready_o), 64'(tbl[r].exp_rdy));
      check($sformatf("t1 mvalid r%0d", r), 64'(mst_ac_valid_o), 64'(tbl[r].exp_mvalid));
      check($sformatf("t1 busy r%0d", r), 64'(busy_o), 64'(tbl[r].exp_busy));
      if (tbl[r].exp_mvalid && tbl[r].mrdy) begin
        if (ac_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL t1 scoreboard r%0d: got beat want none", r);
        end else begin
          e = ac_q.pop_front();
          check($sformatf("t1 addr r%0d", r), mst_ac_addr_o, e.addr);
          check($sformatf("t1 snoop r%0d", r), 64'(mst_ac_snoop_o), 64'(e.snoop));
          check($sformatf("t1 prot r%0d", r), 64'(mst_ac_prot_o), 64'(e.prot));
          cr_q.push_back(e.src);
        end
      end
      if (tbl[r].exp_rdy != 4'b0000) ac_q.push_back(pay(oh_idx(tbl[r].exp_rdy), r));
      tick();
    end
    check("t1 ac_q empty", 64'(ac_q.size()), 64'h0);
    check("t1 cr_q depth", 64'(cr_q.size()), 64'(MO));

    // One CR frees a slot, but only from the following cycle
    mst_cr_valid_i = 1'b1;
    mst_cr_resp_i  = 5'h11;
    req_cr_ready_i = 4'b1111;
    #4;
    check("t3 same-cycle ready", 64'(req_ac_ready_o), 64'h0);
    check("t3 cr_valid", 64'(req_cr_valid_o), 64'(oh(cr_q[0])));
    check("t3 cr_ready", 64'(mst_cr_ready_o), 64'h1);
    void'(cr_q.pop_front());
    tick();
    mst_cr_valid_i = 1'b0;
    #4;
    check("t3 next-cycle ready", 64'(req_ac_ready_o), 64'h1);
    tick();
    #4;
    check("t3 full again", 64'(req_ac_ready_o), 64'h0);
    tick();

    // Payload stability under mst back-pressure
    do_reset();
    req_ac_valid_i = 4'b0100;
    req_ac_addr_i[2*AW +: AW] = 64'h1000;
    req_ac_snoop_i[2*4 +: 4]  = 4'b0111;
    req_ac_prot_i[2*3 +: 3]   = 3'b010;
    #4;
    check("t2 grant", 64'(req_ac_ready_o), 64'h4);
    check("t2 mvalid c0", 64'(mst_ac_valid_o), 64'h0);
    tick();
    req_ac_addr_i[2*AW +: AW] = 64'h2000;
    req_ac_snoop_i[2*4 +: 4]  = 4'b1011;
    for (int unsigned i = 0; i < 5; i++) begin
      #4;
      check($sformatf("t2 mvalid s%0d", i), 64'(mst_ac_valid_o), 64'h1);
      check($sformatf("t2 addr s%0d", i), mst_ac_addr_o, 64'h1000);
      check($sformatf("t2 snoop s%0d", i), 64'(mst_ac_snoop_o), 64'h7);
      check($sformatf("t2 prot s%0d", i), 64'(mst_ac_prot_o), 64'h2);
      check($sformatf("t2 ready s%0d", i), 64'(req_ac_ready_o), 64'h0);
      tick();
    end
    mst_ac_ready_i = 1'b1;
    #4;
    check("t2 drain addr", mst_ac_addr_o, 64'h1000);
    check("t2 drain ready", 64'(req_ac_ready_o), 64'h4);
    tick();
    req_ac_valid_i = 4'b0000;
    #4;
    check("t2 next addr", mst_ac_addr_o, 64'h2000);
    check("t2 next snoop", 64'(mst_ac_snoop_o), 64'hb);
    tick();

    // CR routing in AC order 1,3,0 with a stall on source 3
    do_reset();
    mst_ac_ready_i = 1'b1;
    drive_payloads(0);
    foreach (cr_rdy_tbl[k]) begin
      cr_rdy_tbl[k] = 4'b1111;
    end
    cr_rdy_tbl[1] = 4'b0111;
    cr_resp_tbl[0] = 5'h01;
    cr_resp_tbl[1] = 5'h02;
    cr_resp_tbl[2] = 5'h02;
    cr_resp_tbl[3] = 5'h03;
    for (int unsigned k = 0; k < 3; k++) begin
      req_ac_valid_i = (k == 0) ? 4'b0010 : (k == 1) ? 4'b1000 : 4'b0001;
      #4;
      check($sformatf("t4 grant %0d", k), 64'(req_ac_ready_o), 64'(req_ac_valid_i));
      cr_q.push_back(oh_idx(req_ac_valid_i));
      tick();
    end
    req_ac_valid_i = 4'b0000;
    tick();
    for (int unsigned k = 0; k < 4; k++) begin
      mst_cr_valid_i = 1'b1;
      mst_cr_resp_i  = cr_resp_tbl[k];
      req_cr_ready_i = cr_rdy_tbl[k];
      #4;
      exp_v = oh(cr_q[0]);
      exp_r = cr_rdy_tbl[k][cr_q[0]];
      check($sformatf("t4 cr_valid %0d", k), 64'(req_cr_valid_o), 64'(exp_v));
      check($sformatf("t4 cr_ready %0d", k), 64'(mst_cr_ready_o), 64'(exp_r));
      check($sformatf("t4 cr_resp %0d", k), 64'(req_cr_resp_o), 64'(cr_resp_tbl[k]));
      if (exp_r) void'(cr_q.pop_front());
      tick();
    end
    mst_cr_valid_i = 1'b0;
    #4;
    check("t4 busy idle", 64'(busy_o), 64'h0);
    check("t4 all routed", 64'(cr_q.size()), 64'h0);
    tick();

    // Reset mid-transfer clears everything, pointer restarts at 0
    do_reset();
    mst_ac_ready_i = 1'b1;
    req_ac_valid_i = 4'b0001;
    repeat (4) tick();
    req_ac_valid_i = 4'b0000;
    mst_ac_ready_i = 1'b0;
    #4;
    check("t5 busy before", 64'(busy_o), 64'h1);
    check("t5 mvalid before", 64'(mst_ac_valid_o), 64'h1);
    #1;
    rst_ni         = 1'b0;
    req_ac_valid_i = 4'b1111;
    mst_cr_valid_i = 1'b1;
    req_cr_ready_i = 4'b1111;
    #1;
    check("t5 ac_ready", 64'(req_ac_ready_o), 64'h0);
    check("t5 mvalid", 64'(mst_ac_valid_o), 64'h0);
    check("t5 cr_valid", 64'(req_cr_valid_o), 64'h0);
    check("t5 cr_ready", 64'(mst_cr_ready_o), 64'h0);
    check("t5 busy", 64'(busy_o), 64'h0);
    check("t5 addr", mst_ac_addr_o, 64'h0);
    tick();
    mst_cr_valid_i = 1'b0;
    req_ac_valid_i = 4'b1001;
    #1;
    rst_ni = 1'b1;
    #2;
    check("t5 grant after", 64'(req_ac_ready_o), 64'h1);
    tick();

    // Sources 0 and 3 both held valid
    do_reset();
    mst_ac_ready_i = 1'b1;
    req_ac_valid_i = 4'b1001;
    for (int unsigned k = 0; k < 4; k++) begin
      #4;
      check($sformatf("t6 grant %0d", k), 64'(req_ac_ready_o),
            64'((FixedPrio || (k % 2 == 0)) ? 4'b0001 : 4'b1000));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
